// File: rtl/status_reg.sv
// 6502 processor status register: flag capture, PLP/RTI loads, SEx/CLx, BIT, push formatting,
// branch decode and the one-instruction-delayed IRQ mask. Optional macro: DECIMAL_FLAG_EN.
module status_reg #(
  parameter logic [7:0] RESET_P = 8'h04
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_valid,
  input  logic [3:0] upd_mask,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  input  logic       alu_sign,
  input  logic       ld_en,
  input  logic [7:0] ld_data,
  input  logic       set_en,
  input  logic [2:0] set_op,
  input  logic       bit_en,
  input  logic [7:0] bit_data,
  input  logic       instr_done,
  input  logic       push_brk,
  input  logic [2:0] br_sel,
  output logic [7:0] p_flags,
  output logic [7:0] push_data,
  output logic       carry_out_p,
  output logic       br_taken,
  output logic       irq_mask
);

  // MASKED/OPEN encoding equals the irq_mask value, so irq_mask doubles as the state readback.
  typedef enum logic {
    IRQ_OPEN   = 1'b0,
    IRQ_MASKED = 1'b1
  } irq_state_t;

  irq_state_t irq_state_q, irq_state_d;

  logic n_q, n_d;
  logic v_q, v_d;
  logic i_q, i_d;
  logic z_q, z_d;
  logic c_q, c_d;
  logic d_flag;

`ifdef DECIMAL_FLAG_EN
  logic d_q, d_d;
  assign d_flag = d_q;
  logic unused_bits;
  assign unused_bits = ^{ld_data[5:4], bit_data[5:0]};
`else
  assign d_flag = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{ld_data[5:3], bit_data[5:0]};
`endif

  // Flag next-state: ld_en > set_en > bit_en > alu_valid, only the highest source acts.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
`ifdef DECIMAL_FLAG_EN
    d_d = d_q;
`endif
    if (ld_en) begin
      n_d = ld_data[7];
      v_d = ld_data[6];
      i_d = ld_data[2];
      z_d = ld_data[1];
      c_d = ld_data[0];
`ifdef DECIMAL_FLAG_EN
      d_d = ld_data[3];
`endif
    end else if (set_en) begin
      case (set_op)
        3'd0:    c_d = 1'b0;
        3'd1:    c_d = 1'b1;
        3'd2:    i_d = 1'b0;
        3'd3:    i_d = 1'b1;
`ifdef DECIMAL_FLAG_EN
        3'd4:    d_d = 1'b0;
        3'd5:    d_d = 1'b1;
`endif
        3'd6:    v_d = 1'b0;
        default: ;
      endcase
    end else if (bit_en) begin
      n_d = bit_data[7];
      v_d = bit_data[6];
      z_d = alu_zero;
    end else if (alu_valid) begin
      if (upd_mask[3]) n_d = alu_sign;
      if (upd_mask[2]) v_d = alu_overflow;
      if (upd_mask[1]) z_d = alu_zero;
      if (upd_mask[0]) c_d = alu_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q <= RESET_P[7];
      v_q <= RESET_P[6];
      i_q <= RESET_P[2];
      z_q <= RESET_P[1];
      c_q <= RESET_P[0];
`ifdef DECIMAL_FLAG_EN
      d_q <= RESET_P[3];
`endif
    end else begin
      n_q <= n_d;
      v_q <= v_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
`ifdef DECIMAL_FLAG_EN
      d_q <= d_d;
`endif
    end
  end

  // IRQ mask FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) irq_state_q <= IRQ_MASKED;
    else       irq_state_q <= irq_state_d;
  end

  // Next state follows I as it will be after this clock, so a same-cycle RTI load counts.
  always_comb begin
    irq_state_d = irq_state_q;
    if (instr_done) irq_state_d = i_d ? IRQ_MASKED : IRQ_OPEN;
  end

  always_comb begin
    irq_mask = (irq_state_q == IRQ_MASKED);
  end

  assign p_flags     = {n_q, v_q, 1'b1, 1'b1, d_flag, i_q, z_q, c_q};
  assign push_data   = {n_q, v_q, 1'b1, push_brk, d_flag, i_q, z_q, c_q};
  assign carry_out_p = c_q;

  always_comb begin
    br_taken = 1'b0;
    case (br_sel)
      3'd0: br_taken = ~n_q;
      3'd1: br_taken =  n_q;
      3'd2: br_taken = ~v_q;
      3'd3: br_taken =  v_q;
      3'd4: br_taken = ~c_q;
      3'd5: br_taken =  c_q;
      3'd6: br_taken = ~z_q;
      3'd7: br_taken =  z_q;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_status_reg.sv
// Directed bench for status_reg: reset, ALU capture, write priority, IRQ mask timing,
// BIT and push formatting, branch decode, reset dropping a pending capture.
module tb_status_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid;
  logic [3:0] upd_mask;
  logic       alu_carry, alu_overflow, alu_zero, alu_sign;
  logic       ld_en;
  logic [7:0] ld_data;
  logic       set_en;
  logic [2:0] set_op;
  logic       bit_en;
  logic [7:0] bit_data;
  logic       instr_done;
  logic       push_brk;
  logic [2:0] br_sel;
  logic [7:0] p_flags, push_data;
  logic       carry_out_p, br_taken, irq_mask;

  int checks = 0;
  int failures = 0;
  logic [7:0] br_exp;

  always #5 clk = ~clk;

  status_reg dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .upd_mask(upd_mask),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .alu_sign(alu_sign), .ld_en(ld_en), .ld_data(ld_data), .set_en(set_en),
    .set_op(set_op), .bit_en(bit_en), .bit_data(bit_data), .instr_done(instr_done),
    .push_brk(push_brk), .br_sel(br_sel), .p_flags(p_flags), .push_data(push_data),
    .carry_out_p(carry_out_p), .br_taken(br_taken), .irq_mask(irq_mask)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; upd_mask = 4'h0; alu_carry = 0; alu_overflow = 0; alu_zero = 0;
    alu_sign = 0; ld_en = 0; ld_data = 8'h00; set_en = 0; set_op = 3'd7; bit_en = 0;
    bit_data = 8'h00; instr_done = 0; push_brk = 0; br_sel = 3'd0;
  endtask

  // One clock; inputs return to idle just after the edge and outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
  endtask

  task automatic do_set(input logic [2:0] op, input logic done);
    set_en = 1; set_op = op; instr_done = done;
    step();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    repeat (3) step();
    check("reset_p", p_flags, 8'h34);
    check("reset_irq", {7'd0, irq_mask}, 8'h01);
    check("reset_carry", {7'd0, carry_out_p}, 8'h00);
    reset = 0;
    step();

    // ALU capture, all flags
    alu_valid = 1; upd_mask = 4'hF; alu_carry = 1; alu_overflow = 1; alu_zero = 0; alu_sign = 1;
    step();
    check("alu_all", p_flags, 8'hF5);
    check("alu_carry_out", {7'd0, carry_out_p}, 8'h01);
    check("alu_irq_hold", {7'd0, irq_mask}, 8'h01);
    br_exp = 8'h6A;  // N=1 V=1 Z=0 C=1
    for (int k = 0; k < 8; k++) begin
      br_sel = 3'(k);
      #1;
      check($sformatf("br_sel%0d", k), {7'd0, br_taken}, {7'd0, br_exp[k]});
    end

    // Partial mask: only Z updated
    alu_valid = 1; upd_mask = 4'b0010; alu_zero = 1;
    step();
    check("alu_mask_z", p_flags, 8'hF7);

    // bit_en beats alu_valid
    bit_en = 1; bit_data = 8'h00; alu_zero = 0;
    alu_valid = 1; upd_mask = 4'hF; alu_carry = 0; alu_overflow = 1; alu_sign = 1;
    step();
    check("bit_over_alu", p_flags, 8'h35);

    // ld_en beats set_en
    ld_en = 1; ld_data = 8'hFF; set_en = 1; set_op = 3'd0;
    step();
`ifdef DECIMAL_FLAG_EN
    check("ld_ff", p_flags, 8'hFF);
`else
    check("ld_ff", p_flags, 8'hF7);
`endif
    ld_en = 1; ld_data = 8'h30;
    step();
    check("ld_30", p_flags, 8'h30);
    check("ld_irq_hold", {7'd0, irq_mask}, 8'h01);

    // set_en beats bit_en
    set_en = 1; set_op = 3'd1; bit_en = 1; bit_data = 8'hC0;
    step();
    check("set_over_bit", p_flags, 8'h31);
    do_set(3'd5, 1'b0);
`ifdef DECIMAL_FLAG_EN
    check("sed", p_flags, 8'h39);
    do_set(3'd7, 1'b0);
    check("set_nop", p_flags, 8'h39);
`else
    check("sed", p_flags, 8'h31);
    do_set(3'd7, 1'b0);
    check("set_nop", p_flags, 8'h31);
`endif
    do_set(3'd4, 1'b0);
    check("cld", p_flags, 8'h31);

    // IRQ mask timing
    do_set(3'd3, 1'b0);
    check("sei_p", p_flags, 8'h35);
    do_set(3'd2, 1'b1);
    check("cli_done_p", p_flags, 8'h31);
    check("cli_done_irq", {7'd0, irq_mask}, 8'h00);
    do_set(3'd3, 1'b0);
    check("sei_nodone_p", p_flags, 8'h35);
    check("sei_nodone_irq", {7'd0, irq_mask}, 8'h00);
    instr_done = 1;
    step();
    check("done_irq", {7'd0, irq_mask}, 8'h01);
    ld_en = 1; ld_data = 8'h00; instr_done = 1;
    step();
    check("rti_p", p_flags, 8'h30);
    check("rti_irq", {7'd0, irq_mask}, 8'h00);

    // BIT and push formatting
    do_set(3'd1, 1'b0);
    bit_en = 1; bit_data = 8'hC0; alu_zero = 1;
    step();
    check("bit_c0", p_flags, 8'hF3);
    check("bit_carry_hold", {7'd0, carry_out_p}, 8'h01);
    push_brk = 1;
    #1;
    check("push_brk1", push_data, 8'hF3);
    push_brk = 0;
    #1;
    check("push_brk0", push_data, 8'hE3);

    // Reset drops a concurrent capture
    reset = 1;
    alu_valid = 1; upd_mask = 4'hF; alu_carry = 1; alu_overflow = 1; alu_zero = 1; alu_sign = 1;
    step();
    check("reset_drop_p", p_flags, 8'h34);
    check("reset_drop_irq", {7'd0, irq_mask}, 8'h01);
    reset = 0;
    step();
    check("post_reset_p", p_flags, 8'h34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
